mips_regfile_dumper: RTL

- Read-side master for the 8x32 MIPS register file. It walks a range of register indices through one register-file read port and streams each word out on a valid/ready interface.
- Used to dump architectural state for debug or memory-image output, as the hardware counterpart of a register write sequence.
- Sits beside the register file and shares the read_reg/read_data port through an external mux owned by the integrator.

---
 rtl/mips_dump_pkg.sv | 22 ++
 rtl/mips_registers.sv | 28 ++
 rtl/mips_regfile_dumper.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mips_dump_pkg.sv
// Purpose: shared defaults, FSM state type and index-wrap helper for the register-file dumper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_dump_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 3;
    localparam int NUM_REGS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } dump_state_e;

    // Next register index, wrapping back to 0 after the top register.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned num_regs);
        return (idx + 1) % num_regs;
    endfunction

endpackage

// File: rtl/mips_registers.sv
// Purpose: 8x32 MIPS register file; one synchronous write port, one combinational read port.
// Latency: write visible the cycle after reg_write; read is combinational.
// Backpressure: none; the port is always available.
// Ports: clk; reg_write/write_reg/write_data write side; read_reg -> read_data.
module mips_registers #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg,
    output logic [DATA_W-1:0] read_data
);

    // Storage array: no reset, contents survive a reset of the dumper.
    logic [DATA_W-1:0] regs_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (reg_write) begin
            regs_q[write_reg] <= write_data;
        end
    end

    assign read_data = regs_q[read_reg];

endmodule

// File: rtl/mips_regfile_dumper.sv
// Purpose: walk register indices first_reg..last_reg (wrapping) through one register-file read
//          port and stream each word out on out_valid/out_ready. Optional MIPS_DUMP_PARITY_EN
//          adds out_parity (even parity of out_data).
// Latency: first out_valid 2 cycles after an accepted start; then 1 word/cycle while out_ready=1.
// Backpressure: out_data/out_index/out_last held stable while out_valid & !out_ready.
// Ports: clk, rst_n (async active-low); start/first_reg/last_reg request; rf_read_reg/rf_read_data
//        register-file read port; out_* stream; busy from accepted start to done; done 1-cycle pulse.
import mips_dump_pkg::*;

module mips_regfile_dumper #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
`ifdef MIPS_DUMP_PARITY_EN
    output logic              out_parity,
`endif
    output logic              busy,
    output logic              done
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] lst_q, lst_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              last_q, last_d;
    logic              load;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lst_d   = lst_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = first_reg;
                    lst_d   = last_reg;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                load    = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        // ptr already points at the next word, so its read data is ready now.
                        load = 1'b1;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            data_d  = rf_read_data;
            idx_d   = ptr_q;
            last_d  = (ptr_q == lst_q);
            valid_d = 1'b1;
            ptr_d   = ADDR_W'(next_idx(32'(ptr_q), NUM_REGS));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lst_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lst_q   <= lst_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

`ifdef MIPS_DUMP_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (load) begin
            parity_d = ^rf_read_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

    assign rf_read_reg = ptr_q;
    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_index   = idx_q;
    assign out_last    = last_q;
    assign busy        = busy_q;
    // DONE lasts exactly one cycle, so decoding the state gives the pulse.
    assign done        = (state_q == DONE);

endmodule
